// File: rtl/mem_copy_engine.sv
// mem_copy_engine: AXI-light initiator that copies a block of 32-bit words
// from src to dst, or fills dst with a constant pattern. One job at a time,
// exactly one AXI transaction outstanding, never a read and a write together.
module mem_copy_engine #(
  parameter int          COUNT_WIDTH = 16,
  parameter logic [31:0] ADDR_STEP   = 32'd4
) (
  input  logic                   clk,
  input  logic                   res_n,
  // AXI-light master
  output logic [31:0]            m_axi_awaddr,
  output logic                   m_axi_awvalid,
  input  logic                   m_axi_awready,
  output logic [31:0]            m_axi_wdata,
  output logic [3:0]             m_axi_wstrb,
  output logic                   m_axi_wvalid,
  input  logic                   m_axi_wready,
  input  logic                   m_axi_bvalid,
  output logic                   m_axi_bready,
  output logic [31:0]            m_axi_araddr,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  input  logic [31:0]            m_axi_rdata,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready,
  // command interface
  input  logic                   start,
  input  logic                   fill_mode,
  input  logic [31:0]            src_addr,
  input  logic [31:0]            dst_addr,
  input  logic [COUNT_WIDTH-1:0] word_count,
  input  logic [31:0]            fill_pattern,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] words_done
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_ISSUE, WR_RESP, FINISH
  } state_t;

  typedef struct packed {
    logic                   fill;
    logic [31:0]            src;
    logic [31:0]            dst;
    logic [COUNT_WIDTH-1:0] cnt;
  } job_t;

  state_t                 state, state_nx;
  job_t                   job;
  logic [31:0]            data;      // word in flight: read data or fill pattern
  logic                   aw_done;   // AW accepted during current WR_ISSUE
  logic                   w_done;    // W accepted during current WR_ISSUE
  logic                   aw_ok, w_ok, last;
  logic [COUNT_WIDTH-1:0] wd_inc;

  assign wd_inc = words_done + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  assign last   = (wd_inc == job.cnt);
  // AW and W may complete in either order; a channel counts as finished
  // once its flag is set or its ready is seen this cycle
  assign aw_ok  = aw_done | m_axi_awready;
  assign w_ok   = w_done  | m_axi_wready;

  // state register
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next state and AXI/status outputs; all outputs decode from state so an
  // asynchronous reset drives them to idle values without a clock edge
  always_comb begin
    state_nx      = state;
    m_axi_araddr  = '0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    m_axi_awaddr  = '0;
    m_axi_awvalid = 1'b0;
    m_axi_wdata   = '0;
    m_axi_wstrb   = '0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (word_count == '0) state_nx = FINISH;
          else if (fill_mode)   state_nx = WR_ISSUE;
          else                  state_nx = RD_ADDR;
        end
      end
      RD_ADDR: begin
        busy          = 1'b1;
        m_axi_araddr  = job.src;
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nx = RD_DATA;
      end
      RD_DATA: begin
        busy         = 1'b1;
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) state_nx = WR_ISSUE;
      end
      WR_ISSUE: begin
        busy          = 1'b1;
        m_axi_awaddr  = job.dst;
        m_axi_awvalid = !aw_done;
        m_axi_wdata   = data;
        m_axi_wstrb   = 4'hF;
        m_axi_wvalid  = !w_done;
        if (aw_ok && w_ok) state_nx = WR_RESP;
      end
      WR_RESP: begin
        busy         = 1'b1;
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          if (last)          state_nx = FINISH;
          else if (job.fill) state_nx = WR_ISSUE;
          else               state_nx = RD_ADDR;
        end
      end
      FINISH: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // job registers: latch on accepted start, advance on each B response
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      job        <= '0;
      data       <= '0;
      words_done <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          job.fill   <= fill_mode;
          job.src    <= src_addr;
          job.dst    <= dst_addr;
          job.cnt    <= word_count;
          data       <= fill_pattern;
          words_done <= '0;
        end
        RD_DATA: if (m_axi_rvalid) data <= m_axi_rdata;
        WR_RESP: if (m_axi_bvalid) begin
          words_done <= wd_inc;
          job.src    <= job.src + ADDR_STEP;
          job.dst    <= job.dst + ADDR_STEP;
        end
        default: ;
      endcase
    end
  end

  // per-channel completion flags so each valid drops right after its ready
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state == WR_ISSUE && state_nx == WR_ISSUE) begin
      if (m_axi_awready) aw_done <= 1'b1;
      if (m_axi_wready)  w_done  <= 1'b1;
    end else begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine: a delay-programmable AXI-light slave,
// a handshake monitor, and a linear sequence of jobs with hand-computed
// expectations.
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        res_n;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic        start, fill_mode, busy, done;
  logic [31:0] src_addr, dst_addr, fill_pattern;
  logic [15:0] word_count, words_done;

  always #5 clk = ~clk;

  mem_copy_engine #(.COUNT_WIDTH(16), .ADDR_STEP(32'd4)) dut (
    .clk(clk), .res_n(res_n),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .start(start), .fill_mode(fill_mode), .src_addr(src_addr), .dst_addr(dst_addr),
    .word_count(word_count), .fill_pattern(fill_pattern),
    .busy(busy), .done(done), .words_done(words_done)
  );

  int tests, fails;
  int ar_dly, aw_dly, w_dly, r_dly, b_dly;
  bit idle_rdy, rnd;
  int ar_c, aw_c, w_c, r_c, b_c;
  logic [31:0] last_ar;
  logic [31:0] ar_q[$], aw_q[$], w_q[$];
  logic [3:0]  ws_q[$];
  int b_cnt, awv_cyc, wv_cyc, stab_err, rw_overlap, b_early, busy_err;
  logic p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
  logic [31:0] p_ara, p_awa, p_wd;

  // memory contents seen by reads: a fixed function of the address
  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    ar_q.delete(); aw_q.delete(); w_q.delete(); ws_q.delete();
    b_cnt = 0; awv_cyc = 0; wv_cyc = 0;
  endtask

  // slave: readys/responses updated 1ns after each rising edge
  initial begin
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0; rdata = '0;
    ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0;
    forever begin
      @(posedge clk); #1;
      if (arvalid) begin arready = (ar_c >= ar_dly); ar_c++; end
      else begin arready = idle_rdy; ar_c = 0; end
      if (awvalid) begin awready = (aw_c >= aw_dly); aw_c++; end
      else begin awready = idle_rdy; aw_c = 0; end
      if (wvalid) begin wready = (w_c >= w_dly); w_c++; end
      else begin wready = idle_rdy; w_c = 0; end
      if (rready) begin rvalid = (r_c >= r_dly); rdata = rd_fn(last_ar); r_c++; end
      else begin
        rvalid = 0; r_c = 0;
        if (rnd) r_dly = $urandom_range(0, 7);
      end
      if (bready) begin bvalid = (b_c >= b_dly); b_c++; end
      else begin
        bvalid = 0; b_c = 0;
        if (rnd) b_dly = $urandom_range(0, 7);
      end
    end
  end

  // monitor: on the falling edge, record handshakes due at the next rise
  initial begin
    last_ar = '0;
    p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
    p_ara = '0; p_awa = '0; p_wd = '0;
    forever begin
      @(negedge clk);
      if (arvalid && arready) begin ar_q.push_back(araddr); last_ar = araddr; end
      if (awvalid && awready) aw_q.push_back(awaddr);
      if (wvalid && wready) begin w_q.push_back(wdata); ws_q.push_back(wstrb); end
      if (bvalid && bready) b_cnt++;
      if (awvalid) awv_cyc++;
      if (wvalid) wv_cyc++;
      if (arvalid && (awvalid || wvalid)) rw_overlap++;
      if (bready && (awvalid || wvalid || arvalid)) b_early++;
      if (p_arv && !p_arr && (!arvalid || araddr !== p_ara)) stab_err++;
      if (p_awv && !p_awr && (!awvalid || awaddr !== p_awa)) stab_err++;
      if (p_wv && !p_wr && (!wvalid || wdata !== p_wd)) stab_err++;
      p_arv = arvalid; p_arr = arready; p_ara = araddr;
      p_awv = awvalid; p_awr = awready; p_awa = awaddr;
      p_wv = wvalid; p_wr = wready; p_wd = wdata;
    end
  end

  // cyc = index of the done cycle, 0 being the cycle right after the start edge
  task automatic run_job(input logic fm, input logic [31:0] s, input logic [31:0] d,
                         input logic [15:0] n, input logic [31:0] p, input bit hold,
                         output int cyc, output int ndone);
    @(negedge clk);
    fill_mode = fm; src_addr = s; dst_addr = d; word_count = n; fill_pattern = p; start = 1;
    cyc = -1; ndone = 0;
    @(negedge clk);
    for (int k = 0; k < 400; k++) begin
      if (done) begin
        ndone++; cyc = k;
        if (busy) busy_err++;
        break;
      end
      if (!busy) busy_err++;
      if (hold) begin
        start = 1; src_addr = $urandom; dst_addr = $urandom;
        word_count = 16'($urandom); fill_mode = 1'($urandom); fill_pattern = $urandom;
      end else start = 0;
      @(negedge clk);
    end
    start = 0;
  endtask

  int cyc, nd, extra;
  bit seen;

  initial begin
    tests = 0; fails = 0; busy_err = 0; stab_err = 0; rw_overlap = 0; b_early = 0;
    ar_dly = 0; aw_dly = 0; w_dly = 0; r_dly = 0; b_dly = 0; idle_rdy = 1; rnd = 0;
    start = 0; fill_mode = 0; src_addr = '0; dst_addr = '0; word_count = '0; fill_pattern = '0;
    res_n = 0;
    clear_log();
    repeat (2) @(negedge clk);
    chk("rst_valids", {27'd0, arvalid, awvalid, wvalid, rready, bready}, 32'd0);
    chk("rst_addr_data", awaddr | araddr | wdata, 32'd0);
    chk("rst_wstrb", wstrb, 32'd0);
    chk("rst_busy_done", {busy, done}, 32'd0);
    chk("rst_words_done", words_done, 32'd0);
    @(negedge clk); res_n = 1;
    @(negedge clk);

    // copy 4 words, zero-wait slave (ready before valid)
    clear_log();
    run_job(0, 32'h100, 32'h200, 16'd4, 32'h0, 0, cyc, nd);
    chk("copy4_latency", cyc, 32'd16);
    chk("copy4_words_done", words_done, 32'd4);
    chk("copy4_ar_count", ar_q.size(), 32'd4);
    chk("copy4_aw_count", aw_q.size(), 32'd4);
    chk("copy4_b_count", b_cnt, 32'd4);
    for (int i = 0; i < 4 && i < ar_q.size() && i < w_q.size(); i++) begin
      chk($sformatf("copy4_araddr%0d", i), ar_q[i], 32'h100 + 32'(4 * i));
      chk($sformatf("copy4_awaddr%0d", i), aw_q[i], 32'h200 + 32'(4 * i));
      chk($sformatf("copy4_wdata%0d", i), w_q[i], rd_fn(32'h100 + 32'(4 * i)));
    end
    repeat (3) @(negedge clk);
    chk("copy4_words_done_hold", words_done, 32'd4);

    // fill 3 words
    clear_log();
    run_job(1, 32'h0, 32'h7FFF_FFF0, 16'd3, 32'hDEAD_BEEF, 0, cyc, nd);
    chk("fill3_latency", cyc, 32'd6);
    chk("fill3_no_ar", ar_q.size(), 32'd0);
    chk("fill3_aw_count", aw_q.size(), 32'd3);
    chk("fill3_w_count", w_q.size(), 32'd3);
    for (int i = 0; i < 3 && i < aw_q.size() && i < w_q.size(); i++) begin
      chk($sformatf("fill3_awaddr%0d", i), aw_q[i], 32'h7FFF_FFF0 + 32'(4 * i));
      chk($sformatf("fill3_wdata%0d", i), w_q[i], 32'hDEAD_BEEF);
      chk($sformatf("fill3_wstrb%0d", i), ws_q[i], 32'hF);
    end
    chk("fill3_words_done", words_done, 32'd3);

    // zero-length job: done in the second cycle counting the start cycle
    clear_log();
    run_job(0, 32'h100, 32'h200, 16'd0, 32'h0, 0, cyc, nd);
    chk("zero_latency", cyc, 32'd0);
    chk("zero_no_axi", ar_q.size() + aw_q.size() + w_q.size() + b_cnt, 32'd0);
    chk("zero_words_done", words_done, 32'd0);

    // source address wraps past 2^32
    clear_log();
    run_job(0, 32'hFFFF_FFFC, 32'h300, 16'd2, 32'h0, 0, cyc, nd);
    chk("wrap_ar_count", ar_q.size(), 32'd2);
    if (ar_q.size() == 2 && w_q.size() == 2) begin
      chk("wrap_araddr0", ar_q[0], 32'hFFFF_FFFC);
      chk("wrap_araddr1", ar_q[1], 32'h0000_0000);
      chk("wrap_wdata1", w_q[1], rd_fn(32'h0));
    end
    chk("wrap_words_done", words_done, 32'd2);

    // awready 3 cycles late, wready immediate
    clear_log();
    idle_rdy = 0; aw_dly = 3;
    run_job(1, 32'h0, 32'h40, 16'd1, 32'h1234_5678, 0, cyc, nd);
    chk("bp_latency", cyc, 32'd5);
    chk("bp_awvalid_cycles", awv_cyc, 32'd4);
    chk("bp_wvalid_cycles", wv_cyc, 32'd1);
    chk("bp_awaddr", aw_q.size() == 1 ? aw_q[0] : 32'hX, 32'h40);
    chk("bp_wdata", w_q.size() == 1 ? w_q[0] : 32'hX, 32'h1234_5678);
    idle_rdy = 1; aw_dly = 0;

    // random R/B delays 0..7
    clear_log();
    rnd = 1;
    run_job(0, 32'h1000, 32'h2000, 16'd8, 32'h0, 0, cyc, nd);
    rnd = 0; r_dly = 0; b_dly = 0;
    chk("rnd_done_seen", nd, 32'd1);
    chk("rnd_words_done", words_done, 32'd8);
    chk("rnd_b_count", b_cnt, 32'd8);
    chk("rnd_w_count", w_q.size(), 32'd8);
    for (int i = 0; i < 8 && i < w_q.size() && i < aw_q.size(); i++) begin
      chk($sformatf("rnd_awaddr%0d", i), aw_q[i], 32'h2000 + 32'(4 * i));
      chk($sformatf("rnd_wdata%0d", i), w_q[i], rd_fn(32'h1000 + 32'(4 * i)));
    end

    // start held high with changing inputs during a copy
    clear_log();
    run_job(0, 32'h400, 32'h500, 16'd4, 32'h0, 1, cyc, nd);
    extra = 0;
    repeat (4) begin @(negedge clk); if (done || busy) extra++; end
    chk("hold_latency", cyc, 32'd16);
    chk("hold_no_restart", extra, 32'd0);
    chk("hold_ar_count", ar_q.size(), 32'd4);
    chk("hold_aw_last", aw_q.size() == 4 ? aw_q[3] : 32'hX, 32'h50C);
    chk("hold_ar_last", ar_q.size() == 4 ? ar_q[3] : 32'hX, 32'h40C);
    chk("hold_words_done", words_done, 32'd4);

    // asynchronous reset while waiting in RD_DATA
    clear_log();
    r_dly = 20;
    @(negedge clk);
    fill_mode = 0; src_addr = 32'h800; dst_addr = 32'h900; word_count = 16'd3; start = 1;
    @(negedge clk); start = 0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (rready) begin seen = 1; break; end
      @(negedge clk);
    end
    chk("rst_mid_reached_rd_data", seen, 32'd1);
    #1 res_n = 0;
    #1;
    chk("rst_mid_valids", {27'd0, arvalid, awvalid, wvalid, rready, bready}, 32'd0);
    chk("rst_mid_busy", busy, 32'd0);
    chk("rst_mid_words_done", words_done, 32'd0);
    extra = 0;
    repeat (3) begin @(negedge clk); if (done) extra++; end
    r_dly = 0; res_n = 1;
    repeat (2) begin @(negedge clk); if (done) extra++; end
    chk("rst_mid_no_done", extra, 32'd0);
    clear_log();
    run_job(0, 32'hA00, 32'hB00, 16'd1, 32'h0, 0, cyc, nd);
    chk("post_rst_latency", cyc, 32'd4);
    chk("post_rst_awaddr", aw_q.size() == 1 ? aw_q[0] : 32'hX, 32'hB00);
    chk("post_rst_wdata", w_q.size() == 1 ? w_q[0] : 32'hX, rd_fn(32'hA00));
    chk("post_rst_words_done", words_done, 32'd1);

    // whole-run protocol properties
    chk("busy_until_done", busy_err, 32'd0);
    chk("valid_stability", stab_err, 32'd0);
    chk("no_read_write_overlap", rw_overlap, 32'd0);
    chk("bready_after_aw_w", b_early, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
